// File: rtl/chacha_block_core.sv
// ChaCha block function: four parallel quarter-rounds, one half-round per clock, then final add.
// Latency ROUNDS+1 edges from start to ks_valid; block held until ks_ready, start ignored while busy.
module QRfunction (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d
);
    logic [31:0] w_a1, w_dx1, w_d1, w_c1, w_bx1, w_b1;
    logic [31:0] w_a2, w_dx2, w_d2, w_c2, w_bx2, w_b2;

    // Rotations by 16, 12, 8, 7 written as concatenations.
    assign w_a1  = i_a + i_b;
    assign w_dx1 = i_d ^ w_a1;
    assign w_d1  = {w_dx1[15:0], w_dx1[31:16]};
    assign w_c1  = i_c + w_d1;
    assign w_bx1 = i_b ^ w_c1;
    assign w_b1  = {w_bx1[19:0], w_bx1[31:20]};
    assign w_a2  = w_a1 + w_b1;
    assign w_dx2 = w_d1 ^ w_a2;
    assign w_d2  = {w_dx2[23:0], w_dx2[31:24]};
    assign w_c2  = w_c1 + w_d2;
    assign w_bx2 = w_b1 ^ w_c2;
    assign w_b2  = {w_bx2[24:0], w_bx2[31:25]};

    assign o_a = w_a2;
    assign o_b = w_b2;
    assign o_c = w_c2;
    assign o_d = w_d2;
endmodule

module chacha_block_core #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    input  logic         start,
    output logic         busy,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [511:0] keystream
);
    localparam int RCW = $clog2(ROUNDS + 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} state_t;

    state_t              r_state;
    logic [RCW-1:0]      r_rc;
    logic [15:0][31:0]   r_x;
    logic [15:0][31:0]   r_s;
    logic [15:0][31:0]   r_ks;
    logic                r_ks_vld;

    logic [15:0][31:0]   w_init;
    logic [15:0][31:0]   w_col;
    logic [15:0][31:0]   w_dia;
    logic [15:0][31:0]   w_xn;
    logic [15:0][31:0]   w_sum;
    logic [3:0][31:0]    w_qa, w_qb, w_qc, w_qd;
    logic [3:0][31:0]    w_oa, w_ob, w_oc, w_od;

    assign w_init = {nonce, counter, key,
                     32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    // Lane k always owns word k; diagonal lanes pick b/c/d rotated by 1/2/3 columns.
    for (genvar k = 0; k < 4; k++) begin : g_qr
        localparam int KB = (k + 1) % 4;
        localparam int KC = (k + 2) % 4;
        localparam int KD = (k + 3) % 4;

        assign w_qa[k] = r_x[k];
        assign w_qb[k] = r_rc[0] ? r_x[4 + KB]  : r_x[4 + k];
        assign w_qc[k] = r_rc[0] ? r_x[8 + KC]  : r_x[8 + k];
        assign w_qd[k] = r_rc[0] ? r_x[12 + KD] : r_x[12 + k];

        QRfunction u_qr (
            .i_a (w_qa[k]),
            .i_b (w_qb[k]),
            .i_c (w_qc[k]),
            .i_d (w_qd[k]),
            .o_a (w_oa[k]),
            .o_b (w_ob[k]),
            .o_c (w_oc[k]),
            .o_d (w_od[k])
        );

        assign w_col[k]       = w_oa[k];
        assign w_col[4 + k]   = w_ob[k];
        assign w_col[8 + k]   = w_oc[k];
        assign w_col[12 + k]  = w_od[k];
        assign w_dia[k]       = w_oa[k];
        assign w_dia[4 + KB]  = w_ob[k];
        assign w_dia[8 + KC]  = w_oc[k];
        assign w_dia[12 + KD] = w_od[k];
    end

    for (genvar i = 0; i < 16; i++) begin : g_word
        assign w_xn[i]  = r_rc[0] ? w_dia[i] : w_col[i];
        assign w_sum[i] = r_x[i] + r_s[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rc     <= '0;
            r_x      <= '0;
            r_s      <= '0;
            r_ks     <= '0;
            r_ks_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= w_init;
                        r_s     <= w_init;
                        r_rc    <= '0;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_x  <= w_xn;
                    r_rc <= r_rc + 1'b1;
                    if (r_rc == RC_LAST) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_ks     <= w_sum;
                    r_ks_vld <= 1'b1;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    if (ks_ready) begin
                        r_ks_vld <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign ks_valid  = r_ks_vld;
    assign keystream = r_ks;
endmodule

// File: tb/tb_chacha_block_core.sv
// Randomized scoreboard bench for chacha_block_core against an array-based ChaCha20 model.
module tb_chacha_block_core;
    localparam int ROUNDS = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic         start;
    logic         busy;
    logic         ks_valid;
    logic         ks_ready;
    logic [511:0] keystream;

    int n_checks = 0;
    int n_pass   = 0;
    logic [511:0] exp_q[$];

    chacha_block_core #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .nonce     (nonce),
        .counter   (counter),
        .start     (start),
        .busy      (busy),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .keystream (keystream)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
        logic [31:0] st[16];
        logic [31:0] w[16];
        logic [511:0] res;
        st[0] = 32'h61707865; st[1] = 32'h3320646e; st[2] = 32'h79622d32; st[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) st[4 + i] = k[32*i +: 32];
        st[12] = c;
        for (int i = 0; i < 3; i++) st[13 + i] = n[32*i +: 32];
        w = st;
        for (int r = 0; r < ROUNDS / 2; r++) begin
            {w[0], w[4], w[8],  w[12]} = qr(w[0], w[4], w[8],  w[12]);
            {w[1], w[5], w[9],  w[13]} = qr(w[1], w[5], w[9],  w[13]);
            {w[2], w[6], w[10], w[14]} = qr(w[2], w[6], w[10], w[14]);
            {w[3], w[7], w[11], w[15]} = qr(w[3], w[7], w[11], w[15]);
            {w[0], w[5], w[10], w[15]} = qr(w[0], w[5], w[10], w[15]);
            {w[1], w[6], w[11], w[12]} = qr(w[1], w[6], w[11], w[12]);
            {w[2], w[7], w[8],  w[13]} = qr(w[2], w[7], w[8],  w[13]);
            {w[3], w[4], w[9],  w[14]} = qr(w[3], w[4], w[9],  w[14]);
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = w[i] + st[i];
        return res;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] ks_word(input int i);
        return keystream[32*i +: 32];
    endfunction

    // Scoreboard monitor: every handshake consumes one expected block.
    initial begin
        logic [511:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && ks_valid && ks_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_block", 512'(exp_q.size()), 512'd1);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_block", keystream, exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Issue a start; returns after the accepting edge E0 with inputs scrambled.
    task automatic issue(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                         input bit push);
        @(posedge clk); #1;
        key = k; nonce = n; counter = c; start = 1'b1;
        if (push) exp_q.push_back(ref_block(k, n, c));
        @(posedge clk); #1;
        start = 1'b0; key = rnd256(); nonce = rnd96(); counter = $urandom();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ks_valid && lat < 200);
    endtask

    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    logic [511:0] snap;
    int           lat, cnt, t1, t2;
    bit           ok;

    initial begin
        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

        rst_n = 1'b0; start = 1'b0; ks_ready = 1'b0;
        key = rnd256(); nonce = rnd96(); counter = $urandom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ks_valid", ks_valid, 0);
        check("rst_keystream", keystream, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        ok = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1 key = rnd256(); counter = $urandom();
            @(negedge clk);
            if (busy || ks_valid || keystream !== 512'd0) ok = 0;
        end
        check("idle_stable", ok, 1);

        // RFC vector with consumer ready.
        ks_ready = 1'b1;
        issue(rfc_key, rfc_nonce, 32'd1, 1);
        wait_valid(lat);
        check("rfc_latency", lat, ROUNDS + 1);
        check("rfc_w0", ks_word(0), 32'he4e7f110);
        check("rfc_w1", ks_word(1), 32'h15593bd1);
        check("rfc_w2", ks_word(2), 32'h1fdd0f50);
        check("rfc_w3", ks_word(3), 32'hc47120a3);
        check("rfc_w15", ks_word(15), 32'h4e3c50a2);
        repeat (3) @(posedge clk);

        issue('0, '0, 32'd0, 1);
        wait_valid(lat);
        check("zero_latency", lat, ROUNDS + 1);
        check("zero_w0", ks_word(0), 32'hade0b876);
        check("zero_w1", ks_word(1), 32'h903df1a0);
        repeat (3) @(posedge clk);

        // Backpressure with start toggling while busy.
        ks_ready = 1'b0;
        issue(rnd256(), rnd96(), $urandom(), 1);
        wait_valid(lat);
        check("bp_latency", lat, ROUNDS + 1);
        snap = keystream;
        ok = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1 start = 1'($urandom_range(0, 1)); key = rnd256();
            @(negedge clk);
            if (keystream !== snap || !ks_valid || !busy) ok = 0;
        end
        start = 1'b0;
        check("bp_hold", ok, 1);
        @(posedge clk); #1 ks_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", ks_valid, 0);
        check("bp_busy_drop", busy, 0);
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (busy || ks_valid) ok = 0;
        end
        check("no_queued_start", ok, 1);

        // Reset at rc=7 discards the block.
        issue(rnd256(), rnd96(), $urandom(), 0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ks_valid", ks_valid, 0);
        check("midrst_keystream", keystream, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        ok = 1;
        repeat (30) begin
            @(negedge clk);
            if (busy || ks_valid) ok = 0;
        end
        check("midrst_quiet", ok, 1);
        issue(rfc_key, rfc_nonce, 32'd1, 1);
        wait_valid(lat);
        check("rfc2_latency", lat, ROUNDS + 1);
        check("rfc2_w0", ks_word(0), 32'he4e7f110);
        repeat (3) @(posedge clk);

        // Back-to-back blocks, counter 1 then 2.
        snap[255:0] = rnd256();
        @(posedge clk); #1;
        key = snap[255:0]; nonce = rfc_nonce; counter = 32'd1; start = 1'b1; ks_ready = 1'b1;
        exp_q.push_back(ref_block(snap[255:0], rfc_nonce, 32'd1));
        exp_q.push_back(ref_block(snap[255:0], rfc_nonce, 32'd2));
        @(posedge clk); #1 counter = 32'd2;
        cnt = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (ks_valid) begin
                if (t1 < 0) t1 = cnt;
                else t2 = cnt;
            end
        end
        start = 1'b0;
        check("b2b_first", t1, ROUNDS + 1);
        check("b2b_spacing", t2 - t1, ROUNDS + 3);
        repeat (10) @(posedge clk);
        check("sb_drained", 512'(exp_q.size()), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
